// File: rtl/mac_feeder.sv
// Feeds the mac input interface: pairs buffered matrix nonzeros with vector values,
// issues one product per cycle, tracks the row index and signals end-of-matrix.

module mac_feeder_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // full comes from start-of-cycle occupancy, so a same-cycle pop never frees a slot
  assign full    = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// state   | meaning
// S_IDLE  | waiting for start; FIFOs still accept pushes
// S_RUN   | popping heads, issuing wr, advancing the row counter
// S_FLUSH | no pops, counting down while the mac pipeline drains
// S_EOF   | single-cycle eof pulse, then back to idle
module mac_feeder #(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = 10,
  parameter int FIFO_DEPTH               = 16,
  parameter int LOG2_FIFO_DEPTH          = 4,
  parameter int FLUSH_CYCLES             = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                nz_push,
  input  logic [63:0]                         nz_val,
  input  logic                                nz_row_end,
  input  logic                                nz_empty_row,
  input  logic                                nz_last,
  output logic                                nz_full,
  input  logic                                vec_push,
  input  logic [63:0]                         vec_val,
  output logic                                vec_full,
  output logic                                wr,
  output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
  output logic [63:0]                         v0,
  output logic [63:0]                         v1,
  output logic                                eof,
  output logic                                busy
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [LOG2_INTERMEDIATOR_DEPTH-1:0] ROW_MAX =
    LOG2_INTERMEDIATOR_DEPTH'(INTERMEDIATOR_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_EOF} state_t;

  state_t                              state;
  state_t                              next_state;
  logic [FW-1:0]                       flush_cnt;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_cnt;

  logic [66:0] nz_head;
  logic        nz_empty;
  logic [63:0] vec_head;
  logic        vec_empty;
  logic        pop_nz;
  logic        pop_vec;
  logic        issue;
  logic        row_inc;

  logic        head_empty_row;
  logic        head_last;
  logic        head_row_end;
  logic [63:0] head_val;

  logic        wr_q;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_q;
  logic [63:0] v0_q;
  logic [63:0] v1_q;

  mac_feeder_fifo #(
    .WIDTH(67), .DEPTH(FIFO_DEPTH), .LOG2_DEPTH(LOG2_FIFO_DEPTH)
  ) u_nz_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (nz_push),
    .din  ({nz_empty_row, nz_last, nz_row_end, nz_val}),
    .pop  (pop_nz),
    .dout (nz_head),
    .empty(nz_empty),
    .full (nz_full)
  );

  mac_feeder_fifo #(
    .WIDTH(64), .DEPTH(FIFO_DEPTH), .LOG2_DEPTH(LOG2_FIFO_DEPTH)
  ) u_vec_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (vec_push),
    .din  (vec_val),
    .pop  (pop_vec),
    .dout (vec_head),
    .empty(vec_empty),
    .full (vec_full)
  );

  assign {head_empty_row, head_last, head_row_end, head_val} = nz_head;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop_nz     = 1'b0;
    pop_vec    = 1'b0;
    issue      = 1'b0;
    row_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_RUN;
      end
      S_RUN: begin
        if (!nz_empty) begin
          // an empty-row marker only advances the row; it never consumes a vector value
          if (head_empty_row) begin
            pop_nz  = 1'b1;
            row_inc = 1'b1;
            if (head_last) next_state = S_FLUSH;
          end else if (!vec_empty) begin
            pop_nz  = 1'b1;
            pop_vec = 1'b1;
            issue   = 1'b1;
            row_inc = head_row_end;
            if (head_last) next_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) next_state = S_EOF;
      end
      S_EOF: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (state == S_RUN && next_state == S_FLUSH) begin
      flush_cnt <= FW'(FLUSH_CYCLES);
    end else if (state == S_FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      row_cnt <= '0;
    end else if (row_inc) begin
      row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
    end
  end

  // row/v0/v1 hold the last issued product while wr is low
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      row_q <= '0;
      v0_q  <= '0;
      v1_q  <= '0;
    end else begin
      wr_q <= issue;
      if (issue) begin
        row_q <= row_cnt;
        v0_q  <= head_val;
        v1_q  <= vec_head;
      end
    end
  end

  assign wr   = wr_q;
  assign row  = row_q;
  assign v0   = v0_q;
  assign v1   = v1_q;
  assign eof  = (state == S_EOF);
  assign busy = (state != S_IDLE);
endmodule
